// File: rtl/saph_fpu_arbiter.sv
// saph_fpu_arbiter: shares one pipelined FPU between GPUS requesters.
// Grants one requester per cycle, records the issuer in a tag FIFO, and routes
// each returning result back to the GPU at the FIFO head.
// Optional feature macro: SAPH_FPU_ARB_RR_EN (round-robin pointer; undefined
// gives fixed priority with the lowest index winning).
module saph_fpu_arbiter #(
  parameter int unsigned GPUS  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [GPUS-1:0]      req_trig,
  input  logic [GPUS*32-1:0]   req_lhs,
  input  logic [GPUS*32-1:0]   req_rhs,
  input  logic [GPUS*2-1:0]    req_mode,
  output logic [GPUS-1:0]      req_ready,
  output logic [GPUS-1:0]      res_trig,
  output logic [31:0]          res_data,
  output logic                 fpu_d_trig,
  output logic [31:0]          fpu_d_lhs,
  output logic [31:0]          fpu_d_rhs,
  output logic [1:0]           fpu_d_mode,
  input  logic                 fpu_d_ready,
  input  logic                 fpu_q_trig,
  input  logic [31:0]          fpu_q_res,
  output logic                 busy,
  output logic                 err_underflow
);

  localparam int unsigned IW = (GPUS > 1) ? $clog2(GPUS) : 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [IW-1:0] ptr;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic          can_grant;
  logic          issue;
  logic          pop;
  logic [IW-1:0] head_tag;
  logic [IW-1:0] tag_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Requester index reached by stepping off positions from base, modulo GPUS.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input int unsigned   off);
    return IW'((32'(base) + off) % GPUS);
  endfunction

  // Grants are gated by reset, FPU readiness and a free tag slot; a pop in
  // the same cycle does not free the slot early.
  assign can_grant = rst_n & fpu_d_ready & (count != FULL);

  // Scan requesters starting at ptr and pick the first one asking.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < GPUS; k++) begin
      if (!grant_any && req_trig[wrap_idx(ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_idx(ptr, k);
      end
    end
  end

  assign issue = can_grant & grant_any;

  // Grant vector and issue bus; the bus is zero in cycles without an issue.
  always_comb begin
    req_ready  = '0;
    fpu_d_trig = 1'b0;
    fpu_d_lhs  = '0;
    fpu_d_rhs  = '0;
    fpu_d_mode = '0;
    if (issue) begin
      req_ready  = GPUS'(1) << grant_idx;
      fpu_d_trig = 1'b1;
      fpu_d_lhs  = req_lhs[32*32'(grant_idx) +: 32];
      fpu_d_rhs  = req_rhs[32*32'(grant_idx) +: 32];
      fpu_d_mode = req_mode[2*32'(grant_idx) +: 2];
    end
  end

  // A result pops the head tag only when one is outstanding.
  assign pop      = rst_n & fpu_q_trig & (count != '0);
  assign head_tag = tag_mem[rd_ptr];

  // Route the returning result to the GPU that issued the oldest operation.
  always_comb begin
    res_trig = '0;
    if (pop) begin
      res_trig = GPUS'(1) << head_tag;
    end
  end

  assign res_data = fpu_q_res;
  assign busy     = (count != '0);

`ifdef SAPH_FPU_ARB_RR_EN
  // Round-robin pointer moves just past the most recent winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (32'(grant_idx) == GPUS - 1) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  // Fixed priority: scanning always starts at requester 0.
  assign ptr = '0;
`endif

  // Tag FIFO: push the issuer on every issue, pop on every matched result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_mem[i] <= '0;
      end
    end else begin
      if (issue) begin
        tag_mem[wr_ptr] <= grant_idx;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(issue) - CW'(pop);
    end
  end

  // Sticky flag for a result arriving with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (fpu_q_trig && (count == '0)) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// Scoreboard bench for saph_fpu_arbiter: a queue-based reference model
// predicts grants, issue payloads, routed results and status each cycle; a
// monitor on the falling edge compares what the DUT presents.
module tb_saph_fpu_arbiter;

  localparam int unsigned GPUS  = 4;
  localparam int unsigned DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [GPUS-1:0]      req_trig = '0;
  logic [GPUS*32-1:0]   req_lhs = '0;
  logic [GPUS*32-1:0]   req_rhs = '0;
  logic [GPUS*2-1:0]    req_mode = '0;
  logic [GPUS-1:0]      req_ready;
  logic [GPUS-1:0]      res_trig;
  logic [31:0]          res_data;
  logic                 fpu_d_trig;
  logic [31:0]          fpu_d_lhs;
  logic [31:0]          fpu_d_rhs;
  logic [1:0]           fpu_d_mode;
  logic                 fpu_d_ready = 1'b0;
  logic                 fpu_q_trig = 1'b0;
  logic [31:0]          fpu_q_res = '0;
  logic                 busy;
  logic                 err_underflow;

  saph_fpu_arbiter #(.GPUS(GPUS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_trig(req_trig), .req_lhs(req_lhs), .req_rhs(req_rhs), .req_mode(req_mode),
    .req_ready(req_ready), .res_trig(res_trig), .res_data(res_data),
    .fpu_d_trig(fpu_d_trig), .fpu_d_lhs(fpu_d_lhs), .fpu_d_rhs(fpu_d_rhs),
    .fpu_d_mode(fpu_d_mode), .fpu_d_ready(fpu_d_ready),
    .fpu_q_trig(fpu_q_trig), .fpu_q_res(fpu_q_res),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [1:0]  mode;
  } issue_t;

  typedef struct packed {
    logic [GPUS-1:0] trig;
    logic [31:0]     data;
  } res_t;

  typedef struct packed {
    logic [GPUS-1:0] ready;
    logic            busy;
    logic            err;
  } stat_t;

  issue_t iss_q[$];
  res_t   res_q[$];
  stat_t  st_q[$];

  // Reference model state: next requester to consider, outstanding issuers in
  // order, and the sticky underflow flag.
  int m_ptr = 0;
  int m_tags[$];
  bit m_err = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Predict this cycle's outputs from the current inputs, then advance the
  // model as the coming clock edge would.
  task automatic model_step();
    stat_t  s;
    issue_t is;
    res_t   r;
    int     gx;
    if (!rst_n) begin
      m_ptr = 0;
      m_tags.delete();
      m_err = 1'b0;
      s = '0;
      st_q.push_back(s);
      return;
    end
    s.busy  = (m_tags.size() != 0);
    s.err   = m_err;
    gx = -1;
    if (fpu_d_ready && m_tags.size() < DEPTH) begin
      for (int k = 0; k < GPUS; k++) begin
        if (req_trig[(m_ptr + k) % GPUS] && gx < 0) gx = (m_ptr + k) % GPUS;
      end
    end
    s.ready = (gx >= 0) ? (GPUS'(1) << gx) : '0;
    if (gx >= 0) begin
      is.lhs  = req_lhs[gx*32 +: 32];
      is.rhs  = req_rhs[gx*32 +: 32];
      is.mode = req_mode[gx*2 +: 2];
      iss_q.push_back(is);
    end
    if (fpu_q_trig) begin
      if (m_tags.size() > 0) begin
        r.trig = GPUS'(1) << m_tags[0];
        r.data = fpu_q_res;
        res_q.push_back(r);
        void'(m_tags.pop_front());
      end else begin
        m_err = 1'b1;
      end
    end
    if (gx >= 0) begin
      m_tags.push_back(gx);
`ifdef SAPH_FPU_ARB_RR_EN
      m_ptr = (gx + 1) % GPUS;
`endif
    end
    st_q.push_back(s);
  endtask

  // Monitor: compare whatever the DUT presents against the queued predictions.
  always @(negedge clk) begin
    stat_t  s;
    issue_t is;
    res_t   r;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk("req_ready", 64'(req_ready), 64'(s.ready));
      chk("busy", 64'(busy), 64'(s.busy));
      chk("err_underflow", 64'(err_underflow), 64'(s.err));
      if (fpu_d_trig) begin
        if (iss_q.size() == 0) begin
          chk("unexpected_issue", 64'(fpu_d_trig), 64'(0));
        end else begin
          is = iss_q.pop_front();
          chk("issue_payload", 64'({fpu_d_lhs, fpu_d_rhs, fpu_d_mode}),
              64'({is.lhs, is.rhs, is.mode}));
        end
      end else begin
        chk("idle_issue_bus", 64'({fpu_d_lhs, fpu_d_rhs, fpu_d_mode}), 64'(0));
        if (iss_q.size() > 0) begin
          void'(iss_q.pop_front());
          chk("missing_issue", 64'(fpu_d_trig), 64'(1));
        end
      end
      chk("res_data_passthru", 64'(res_data), 64'(fpu_q_res));
      if (res_trig != '0) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", 64'(res_trig), 64'(0));
        end else begin
          r = res_q.pop_front();
          chk("result_route", 64'({res_trig, res_data}), 64'({r.trig, r.data}));
        end
      end else if (res_q.size() > 0) begin
        r = res_q.pop_front();
        chk("missing_result", 64'(res_trig), 64'(r.trig));
      end
    end
  end

  task automatic rand_operands();
    for (int g = 0; g < GPUS; g++) begin
      req_lhs[g*32 +: 32] = $urandom;
      req_rhs[g*32 +: 32] = $urandom;
      req_mode[g*2 +: 2]  = 2'($urandom_range(3, 0));
    end
    fpu_q_res = $urandom;
  endtask

  // Apply the current inputs for one cycle.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_trig   = '0;
    fpu_q_trig = 1'b1;
    for (int i = 0; i < 2 * DEPTH && m_tags.size() > 0; i++) begin
      rand_operands();
      step();
    end
    fpu_q_trig = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Everyone requesting with the FPU always ready: fill, stall, free one slot.
    fpu_d_ready = 1'b1;
    req_trig    = '1;
    for (int i = 0; i < 6; i++) begin
      rand_operands();
      step();
    end
    fpu_q_trig = 1'b1;
    rand_operands();
    step();
    fpu_q_trig = 1'b0;
    rand_operands();
    step();
    drain();

    // Issues from GPUs 2, 0, 3 followed by their results in order.
    req_trig = 4'b0100; rand_operands(); step();
    req_trig = 4'b0001; rand_operands(); step();
    req_trig = 4'b1000; rand_operands(); step();
    req_trig = '0;
    fpu_q_trig = 1'b1;
    fpu_q_res = 32'h3F80_0000; step();
    fpu_q_res = 32'h4000_0000; step();
    fpu_q_res = 32'h4040_0000; step();
    fpu_q_trig = 1'b0;
    step();

    // Simultaneous issue and result at two outstanding.
    req_trig = 4'b0001; rand_operands(); step();
    req_trig = 4'b0100; rand_operands(); step();
    req_trig = 4'b0010; fpu_q_trig = 1'b1; rand_operands(); step();
    fpu_q_trig = 1'b0; req_trig = '0; step();
    drain();

    // Reset with two outstanding, then a stray result.
    req_trig = 4'b0011; rand_operands(); step(); step();
    req_trig = '0;
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    fpu_q_trig = 1'b1; rand_operands(); step();
    fpu_q_trig = 1'b0; step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      rand_operands();
      req_trig    = GPUS'($urandom);
      fpu_d_ready = ($urandom_range(3, 0) != 0);
      fpu_q_trig  = ($urandom_range(2, 0) == 0);
      rst_n       = ($urandom_range(199, 0) != 0);
      step();
    end
    rst_n = 1'b1;
    req_trig = '0;
    fpu_q_trig = 1'b0;
    step();
    @(negedge clk);
    #1;
    chk("leftover_expectations", 64'(iss_q.size() + res_q.size() + st_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/saph_fpu_arbiter.md
SAPH_FPU_ARBITER -- requirements
Module: saph_fpu_arbiter

Interface
REQ-001 SHALL have parameter GPUS, default 4, number of requesting GPU ports (>=2).
REQ-002 SHALL have parameter DEPTH, default 4, maximum number of FPU operations outstanding (power of two, >=2).
REQ-003 SHALL have port clk, in, 1, the single core clock.
REQ-004 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_trig, in, GPUS, per-GPU operation request.
REQ-006 SHALL have ports req_lhs and req_rhs, in, GPUS*32, per-GPU operands; slice x is bits [32x+31:32x].
REQ-007 SHALL have port req_mode, in, GPUS*2, per-GPU operation mode.
REQ-008 SHALL have port req_ready, out, GPUS, per-GPU grant.
REQ-009 SHALL have port res_trig, out, GPUS, per-GPU result valid.
REQ-010 SHALL have port res_data, out, 32, result broadcast to all GPUs.
REQ-011 SHALL have ports fpu_d_trig (out, 1), fpu_d_lhs (out, 32), fpu_d_rhs (out, 32), fpu_d_mode (out, 2) and fpu_d_ready (in, 1) for FPU issue.
REQ-012 SHALL have ports fpu_q_trig (in, 1) and fpu_q_res (in, 32) for FPU results.
REQ-013 SHALL have port busy, out, 1, high while any operation is outstanding.
REQ-014 SHALL have port err_underflow, out, 1, sticky flag for an unexpected FPU result.

Function
REQ-015 SHALL assert at most one req_ready bit per cycle, combinationally, only when fpu_d_ready=1 and the tag FIFO is not full.
REQ-016 SHALL grant the first requester with req_trig=1 found by scanning from pointer ptr upward, modulo GPUS.
REQ-017 SHALL treat req_trig[x]&req_ready[x] as an issue, driving fpu_d_trig=1 and the slice-x operands and mode onto fpu_d_* in that same cycle.
REQ-018 SHALL drive fpu_d_trig, fpu_d_lhs, fpu_d_rhs and fpu_d_mode to 0 in any cycle without an issue.
REQ-019 SHALL update ptr to (x+1) mod GPUS on the clock edge after an issue from x; otherwise ptr holds.
REQ-020 SHALL push the issuing index x (clog2(GPUS) bits) into a DEPTH-entry tag FIFO on every issue.
REQ-021 SHALL pop the FIFO head on fpu_q_trig=1 when it is non-empty, asserting res_trig[head]=1 in the same cycle.
REQ-022 SHALL pass fpu_q_res to res_data unregistered in every cycle.
REQ-023 SHALL perform push and pop in the same cycle when both occur, leaving count unchanged.
REQ-024 SHALL withhold all grants while count==DEPTH, even when a pop occurs in that cycle.
REQ-025 SHALL, on fpu_q_trig=1 while the FIFO is empty, set err_underflow, assert no res_trig and leave count at 0.
REQ-026 SHALL drive busy = (count!=0).
REQ-027 SHALL let a requester deassert req_trig before being granted without changing any state.
REQ-028 SHALL wrap FIFO read and write pointers modulo DEPTH; count is clog2(DEPTH)+1 bits.

Reset
REQ-029 SHALL asynchronously clear ptr, count, FIFO pointers and err_underflow on rst_n=0, independent of clk.
REQ-030 SHALL hold every output at 0 while rst_n=0, except res_data, which follows fpu_q_res.
REQ-031 SHALL discard all outstanding tags when reset is asserted mid-operation; a later fpu_q_trig then sets err_underflow per REQ-025.

Configuration
REQ-032 SHALL enable round-robin arbitration when the macro SAPH_FPU_ARB_RR_EN is defined: ptr behaves per REQ-016 and REQ-019.
REQ-033 SHALL, when SAPH_FPU_ARB_RR_EN is undefined, tie ptr to 0, giving fixed priority with the lowest index winning; all other behaviour is unchanged.

Verification
REQ-034 SHALL cover: GPUS=4 with RR enabled, req_trig=4'b1111 and fpu_d_ready=1 held -> grant order 0,1,2,3,0 on consecutive cycles.
REQ-035 SHALL cover: same stimulus with the macro undefined -> requester 0 granted every cycle and res_trig only ever on bit 0.
REQ-036 SHALL cover: DEPTH=4 with no fpu_q_trig -> four issues, then req_ready=0 and busy=1; one fpu_q_trig -> res_trig on the first issuer, then a grant in the next cycle.
REQ-037 SHALL cover: issues from GPUs 2,0,3 and fpu_q_res=32'h3F800000,32'h40000000,32'h40400000 -> res_trig 4'b0100,4'b0001,4'b1000 with matching res_data.
REQ-038 SHALL cover: issue and fpu_q_trig in the same cycle at count=2 -> count stays 2 and the correct tag is popped.
REQ-039 SHALL cover: rst_n pulsed low with 2 outstanding, then fpu_q_trig=1 -> err_underflow=1, res_trig=0 and busy=0.
